// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide by zero returns all-ones quotient and the dividend as remainder.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_div_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   step;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;

    // Returns {quotient bit, new partial remainder}; the trial subtract is one bit
    // wider than the operands so its MSB is the borrow.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] part_rem,
        input logic             bit_in,
        input logic [WIDTH-1:0] divisor
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {part_rem, bit_in};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH])
            restore_step = {1'b1, trial[WIDTH-1:0]};
        else
            restore_step = {1'b0, shifted[WIDTH-1:0]};
    endfunction

    always_comb begin
        step      = restore_step(rem, dvd[WIDTH-1], dvs);
        q_bit     = step[WIDTH];
        rem_next  = step[WIDTH-1:0];
        quot_next = {dvd[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        dvd    <= i_dividend;
                        dvs    <= i_divisor;
                        rem    <= '0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        if (i_divisor == '0) begin
                            state       <= DONE;
                            o_quotient  <= '1;
                            o_remainder <= i_dividend;
                            o_div_zero  <= 1'b1;
                            o_valid     <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
                    rem <= rem_next;
                    dvd <= quot_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state       <= DONE;
                        o_quotient  <= quot_next;
                        o_remainder <= rem_next;
                        o_div_zero  <= 1'b0;
                        o_valid     <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed table, corner sequences,
// exhaustive back-to-back sweep and randomized operations against an arithmetic model.
module tb_seq_divider;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid;
    logic         busy;
    logic         div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
    } vec_t;

    vec_t vecs[6];

    seq_divider #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_quotient (quotient),
        .o_remainder(remainder),
        .o_valid    (valid),
        .o_busy     (busy),
        .o_div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one division from IDLE and returns results plus timing observations.
    // lat counts edges after the accepting edge until o_valid is seen.
    task automatic run_div(input int a, input int b, output int q, output int r,
                           output int dz, output int lat, output int bcnt,
                           output int vafter);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = int'(busy);
        while (!valid && lat < 20) begin
            tick();
            lat++;
            bcnt += int'(busy);
        end
        q  = int'(quotient);
        r  = int'(remainder);
        dz = int'(div_zero);
        tick();
        bcnt  += int'(busy);
        vafter = int'(valid);
    endtask

    task automatic check_op(input string tag, input int a, input int b,
                            input int q, input int r, input int dz, input int lat,
                            input int bcnt, input int vafter);
        int eq, er, edz, elat;
        if (b == 0) begin
            eq = MAXV; er = a; edz = 1; elat = 0;
        end else begin
            eq = a / b; er = a % b; edz = 0; elat = W;
        end
        chk($sformatf("%s %0d/%0d quotient", tag, a, b), q, eq);
        chk($sformatf("%s %0d/%0d remainder", tag, a, b), r, er);
        chk($sformatf("%s %0d/%0d div_zero", tag, a, b), dz, edz);
        chk($sformatf("%s %0d/%0d latency", tag, a, b), lat, elat);
        chk($sformatf("%s %0d/%0d busy_cycles", tag, a, b), bcnt, elat + 1);
        chk($sformatf("%s %0d/%0d valid_width", tag, a, b), vafter, 0);
    endtask

    initial begin
        int q, r, dz, lat, bcnt, vafter;
        int vcnt, vcyc, cq, cr;

        vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1, dz: 0};
        vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, dz: 0};
        vecs[2] = '{a: 2,  b: 7,  q: 0,  r: 2, dz: 0};
        vecs[3] = '{a: 15, b: 15, q: 1,  r: 0, dz: 0};
        vecs[4] = '{a: 9,  b: 0,  q: 15, r: 9, dz: 1};
        vecs[5] = '{a: 8,  b: 2,  q: 4,  r: 0, dz: 0};

        // Reset is asynchronous: outputs must be clear before any clock edge.
        #3;
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset div_zero", int'(div_zero), 0);
        tick();
        tick();
        rst = 1'b0;

        // Directed table; the first start follows reset release directly.
        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, dz, lat, bcnt, vafter);
            chk($sformatf("table%0d quotient", i), q, vecs[i].q);
            chk($sformatf("table%0d remainder", i), r, vecs[i].r);
            chk($sformatf("table%0d div_zero", i), dz, vecs[i].dz);
            chk($sformatf("table%0d latency", i), lat, vecs[i].dz ? 0 : W);
            chk($sformatf("table%0d busy_cycles", i), bcnt, vecs[i].dz ? 1 : W + 1);
            chk($sformatf("table%0d valid_width", i), vafter, 0);
        end

        // Start and operand changes during CALC and DONE must not disturb 13/3.
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        dividend = 4'd6;
        divisor  = 4'd2;
        vcnt = 0; vcyc = -1; cq = -1; cr = -1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) begin dividend = 4'd1; divisor = 4'd0; end
            if (cyc == 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            if (valid) begin
                vcnt++;
                vcyc = cyc;
                cq = int'(quotient);
                cr = int'(remainder);
            end
        end
        chk("ignore_start valid_count", vcnt, 1);
        chk("ignore_start valid_cycle", vcyc, W);
        chk("ignore_start quotient", cq, 4);
        chk("ignore_start remainder", cr, 1);
        chk("ignore_start idle_after", int'(busy), 0);

        // Reset at E2 of 13/3 aborts the operation and clears prior results.
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort quotient", int'(quotient), 0);
        chk("abort remainder", int'(remainder), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort div_zero", int'(div_zero), 0);
        vcnt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            vcnt += int'(valid) + int'(busy);
        end
        chk("abort no_valid_or_busy", vcnt, 0);
        rst = 1'b0;
        run_div(7, 2, q, r, dz, lat, bcnt, vafter);
        check_op("after_abort", 7, 2, q, r, dz, lat, bcnt, vafter);

        // Exhaustive sweep, each start issued in the IDLE cycle right after DONE.
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                run_div(a, b, q, r, dz, lat, bcnt, vafter);
                check_op("sweep", a, b, q, r, dz, lat, bcnt, vafter);
                if (b != 0) chk($sformatf("sweep %0d/%0d identity", a, b), q * b + r, a);
            end
        end

        // Random operations with idle gaps; results must hold between operations.
        for (int n = 0; n < 60; n++) begin
            int a, b, gap;
            a = int'($urandom_range(0, MAXV));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, MAXV));
            run_div(a, b, q, r, dz, lat, bcnt, vafter);
            check_op("random", a, b, q, r, dz, lat, bcnt, vafter);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                tick();
            end
            chk($sformatf("random%0d hold_quotient", n), int'(quotient), (b == 0) ? MAXV : a / b);
            chk($sformatf("random%0d hold_remainder", n), int'(remainder), (b == 0) ? a : a % b);
            chk($sformatf("random%0d hold_div_zero", n), int'(div_zero), (b == 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port i_start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 The module SHALL have port i_dividend, input, WIDTH bits: unsigned dividend, sampled with i_start.
REQ-006 The module SHALL have port i_divisor, input, WIDTH bits: unsigned divisor, sampled with i_start.
REQ-007 The module SHALL have port o_quotient, output, WIDTH bits: registered unsigned quotient.
REQ-008 The module SHALL have port o_remainder, output, WIDTH bits: registered unsigned remainder.
REQ-009 The module SHALL have port o_valid, output, 1 bit: one-cycle pulse marking new results.
REQ-010 The module SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The module SHALL have port o_div_zero, output, 1 bit: registered flag, set when the last accepted divisor was 0.

Function
REQ-012 The module SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 In IDLE with i_start=1 at edge E0, the module SHALL latch both operands, clear the partial remainder and the iteration counter, and go to CALC (divisor != 0) or DONE (divisor == 0).
REQ-014 In CALC, the module SHALL perform one restoring-division step per edge, MSB first: shift {remainder, dividend} left 1; trial = remainder - divisor in WIDTH+1 bits; if no borrow, keep the difference and set the quotient bit to 1, else restore and set it to 0.
REQ-015 After exactly WIDTH CALC edges (E1..E_WIDTH), the module SHALL load o_quotient/o_remainder and enter DONE at edge E_WIDTH.
REQ-016 o_valid SHALL be 1 only while in DONE (exactly one cycle); DONE SHALL go to IDLE on the next edge unconditionally.
REQ-017 Latency SHALL be: o_valid high in the cycle after edge E_WIDTH for divisor != 0, and in the cycle after E0 for divisor == 0.
REQ-018 Divide by zero SHALL produce o_quotient = all ones, o_remainder = the dividend, and o_div_zero = 1.
REQ-019 o_div_zero SHALL be cleared to 0 on entry to DONE for any nonzero divisor.
REQ-020 i_start SHALL be ignored in CALC and DONE; operand changes after E0 SHALL NOT affect the running division.
REQ-021 o_quotient, o_remainder and o_div_zero SHALL hold their values from DONE entry until the next DONE entry.
REQ-022 i_start asserted in the IDLE cycle immediately following DONE SHALL be accepted, giving back-to-back operations every WIDTH+2 cycles.
REQ-023 The results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor, including dividend < divisor (quotient = 0) and the maximum operands.

Reset
REQ-024 While i_rst=1, the module SHALL be in IDLE with o_quotient=0, o_remainder=0, o_valid=0, o_busy=0, o_div_zero=0, and the internal counter and registers at 0, regardless of the clock.
REQ-025 Asserting i_rst in CALC or DONE SHALL abort the operation immediately: no o_valid pulse, and the prior results are lost.
REQ-026 After i_rst deasserts, the first i_start SHALL be accepted on the first rising edge.

Verification (WIDTH=4)
REQ-027 The bench SHALL cover: start with 13/3 -> o_busy high for 5 cycles; o_valid pulse in the cycle after E4 with quotient=4, remainder=1, o_div_zero=0.
REQ-028 The bench SHALL cover: 15/1 -> quotient=15, remainder=0; 2/7 -> quotient=0, remainder=2; 15/15 -> quotient=1, remainder=0.
REQ-029 The bench SHALL cover: 9/0 -> o_valid in the cycle after E0 with quotient=15, remainder=9, o_div_zero=1; a following 8/2 -> quotient=4, remainder=0, o_div_zero=0.
REQ-030 The bench SHALL cover: i_start pulsed with 6/2 during CALC of 13/3 -> ignored; a single o_valid with quotient=4, remainder=1; operands changed mid-CALC have no effect.
REQ-031 The bench SHALL cover: i_rst asserted at E2 of 13/3 -> all outputs 0 asynchronously and no o_valid; after release, 7/2 -> quotient=3, remainder=1.
REQ-032 The bench SHALL cover: an exhaustive 4-bit sweep with back-to-back starts, checked against REQ-023 and the REQ-018 divide-by-zero values.
